// File: rtl/acc_reg32_if.sv
// Handshake bundle between the MAC partial-sum source, the accumulator and the ReLU side.
// The slave modport is the accumulator's view; master is the driver/consumer view.
interface acc_reg32_if #(
    parameter int DW = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 in_first;
    logic                 in_last;
    logic signed [DW-1:0] bias;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_data;
    logic                 out_ovf;
    logic                 proto_err;

    modport slave (
        input  in_valid, in_data, in_first, in_last, bias, out_ready,
        output in_ready, out_valid, out_data, out_ovf, proto_err
    );

    modport master (
        output in_valid, in_data, in_first, in_last, bias, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, proto_err
    );
endinterface

// File: rtl/acc_reg32.sv
// Group accumulator feeding ReLU/requantise: bias-seeded sum of signed partial sums,
// one held result under valid/ready, with per-group overflow flag and framing-error pulse.
module acc_reg32 #(
    parameter int DW  = 32,
    parameter bit SAT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    acc_reg32_if.slave  bus
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, HOLD = 2'd2} state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 out_valid_q;
    logic signed [DW-1:0] acc_q;
    logic                 ovf_q;
    logic                 proto_err_q;

    logic                 in_ready_c;
    logic                 accept;
    logic                 do_seed;
    logic                 do_add;
    logic                 err_c;
    logic [DW:0]          seed_res;
    logic [DW:0]          add_res;

    // Returns {overflow, result}; the add is done one bit wider so the true sign is kept.
    function automatic logic [DW:0] add_chk(input logic signed [DW-1:0] a,
                                            input logic signed [DW-1:0] b);
        logic signed [DW:0]   s;
        logic                 ovf;
        logic signed [DW-1:0] res;
        s   = {a[DW-1], a} + {b[DW-1], b};
        ovf = (a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]);
        if (ovf && SAT)
            res = a[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            res = s[DW-1:0];
        return {ovf, res};
    endfunction

    assign seed_res = add_chk(bus.bias, bus.in_data);
    assign add_res  = add_chk(acc_q, bus.in_data);

    // State register; out_valid is registered alongside so it never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d == HOLD);
        end
    end

    // Next state; a beat accepted in HOLD can only happen with out_ready=1,
    // so HOLD then follows the IDLE rules in the same cycle.
    always_comb begin
        state_d = state_q;
        do_seed = 1'b0;
        do_add  = 1'b0;
        err_c   = 1'b0;
        case (state_q)
            IDLE, HOLD: begin
                if (state_q == HOLD && bus.out_ready)
                    state_d = IDLE;
                if (accept) begin
                    if (bus.in_first) begin
                        do_seed = 1'b1;
                        state_d = bus.in_last ? HOLD : ACC;
                    end else begin
                        err_c   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            ACC: begin
                if (accept) begin
                    if (bus.in_first) begin
                        do_seed = 1'b1;
                        err_c   = 1'b1;
                    end else begin
                        do_add  = 1'b1;
                    end
                    state_d = bus.in_last ? HOLD : ACC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs; in_ready depends on state and out_ready only.
    always_comb begin
        in_ready_c = (state_q == HOLD) ? bus.out_ready : 1'b1;
        accept     = bus.in_valid && in_ready_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= err_c;
            if (do_seed) begin
                acc_q <= seed_res[DW-1:0];
                ovf_q <= seed_res[DW];
            end else if (do_add) begin
                acc_q <= add_res[DW-1:0];
                ovf_q <= ovf_q | add_res[DW];
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.proto_err = proto_err_q;

endmodule
